strip_result_drain: RTL and testbench

- Reads the convolution-result buffer of one horizontal strip, over the buffer's external read address port, once the conv unit signals done.
- Streams the results out in address order on a valid/ready interface towards the output-frame assembler.
- Compensates for the fixed BRAM read latency with a credit-limited skid FIFO, so backpressure never loses or duplicates a result.

---
 rtl/strip_result_drain.sv | 192 +++++++++++++++++++
 tb/tb_strip_result_drain.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/strip_result_drain.sv
// Purpose: drain one strip of conv results from the result BRAM and stream them out in address order.
// Latency: first beat is valid after edge E0+RD_LATENCY+1, where E0 samples the conv_done rise. 1 beat/cycle sustained.
// Backpressure: reads are credit-limited against skid FIFO space, so an m_ready stall never drops or repeats a word.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   conv_done             level from conv unit; rising edge starts a drain
//   rd_en/rd_addr/rd_data result BRAM read port (fixed RD_LATENCY)
//   m_valid/m_ready/m_data/m_last  result stream; m_last marks address NUM_RESULTS-1
//   busy, drain_done      status: draining / drain complete

// Small generic FIFO. Caller never pushes when full or pops when empty.
module srd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is reset, so the head reads as zero straight out of reset.
    assign pop_dat = mem[rd_ptr];
    assign empty   = (cnt == '0);
    assign count   = cnt;
endmodule

module strip_result_drain #(
    parameter int DATA_W      = 23,
    parameter int ADDR_W      = 13,
    parameter int NUM_RESULTS = 6216,
    parameter int RD_LATENCY  = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              conv_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              drain_done
);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int CW  = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FLUSH, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              conv_done_q;
    logic              primed_q;
    logic [ADDR_W-1:0] issue_cnt_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [RD_LATENCY-1:0] pipe_last_q;

    logic              start;
    logic              issue_last;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     used;
    logic              credit_ok;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [FCW-1:0]    fifo_cnt;
    logic [DATA_W:0]   fifo_head;

    // primed_q requires conv_done to have been seen low since reset, so a
    // conv_done still high when reset is released does not start a drain.
    assign start      = primed_q && !conv_done_q && conv_done;
    assign issue_last = (issue_cnt_q == ADDR_W'(NUM_RESULTS - 1));

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(pipe_vld_q[i]);
    end

    // Every issued read is either in the latency pipe or in the FIFO, so this
    // sum bounds FIFO fill. A same-cycle pop does not return credit early.
    assign used      = CW'(fifo_cnt) + inflight;
    assign credit_ok = (used < CW'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: begin
                if (credit_ok) begin
                    rd_en = 1'b1;
                    if (issue_last) state_d = S_FLUSH;
                end
            end
            S_FLUSH: if (inflight == '0 && fifo_empty) state_d = S_DONE;
            S_DONE:  if (!conv_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            conv_done_q <= 1'b0;
            primed_q    <= 1'b0;
            issue_cnt_q <= '0;
            last_addr_q <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            state_q     <= state_d;
            conv_done_q <= conv_done;
            primed_q    <= primed_q | ~conv_done;
            if (start)      issue_cnt_q <= '0;
            else if (rd_en) issue_cnt_q <= issue_cnt_q + 1'b1;
            if (rd_en)      last_addr_q <= issue_cnt_q;
            pipe_vld_q[0]  <= rd_en;
            pipe_last_q[0] <= rd_en && issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
        end
    end

    // Address is driven combinationally so the first read goes out the cycle after E0.
    assign rd_addr = rd_en ? issue_cnt_q : last_addr_q;

    assign fifo_push = pipe_vld_q[RD_LATENCY-1];
    assign fifo_pop  = m_valid && m_ready;

    srd_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH),
        .CW    (FCW)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .push_dat ({pipe_last_q[RD_LATENCY-1], rd_data}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    assign m_valid    = !fifo_empty;
    assign m_data     = fifo_head[DATA_W-1:0];
    assign m_last     = fifo_head[DATA_W];
    assign busy       = (state_q == S_ISSUE) || (state_q == S_FLUSH);
    assign drain_done = (state_q == S_DONE);
endmodule

// File: tb/tb_strip_result_drain.sv
module tb_strip_result_drain;
    localparam int DW = 23;
    localparam int AW = 13;
    localparam int N  = 6216;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, conv_done, rd_en, m_valid, m_ready, m_last, busy, drain_done;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data, m_data, bram_d1;

    logic          conv_done_s, rd_en_s, m_valid_s, m_ready_s, m_last_s, busy_s, drain_done_s;
    logic [AW-1:0] rd_addr_s;
    logic [DW-1:0] rd_data_s, m_data_s, bram_d1_s;

    int checks   = 0;
    int failures = 0;
    int exp_idx  = 0;
    int outstanding = 0;

    strip_result_drain dut (
        .clk(clk), .reset_n(reset_n), .conv_done(conv_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .drain_done(drain_done)
    );

    strip_result_drain #(.NUM_RESULTS(1)) dut_one (
        .clk(clk), .reset_n(reset_n), .conv_done(conv_done_s),
        .rd_en(rd_en_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
        .m_valid(m_valid_s), .m_ready(m_ready_s), .m_data(m_data_s), .m_last(m_last_s),
        .busy(busy_s), .drain_done(drain_done_s)
    );

    function automatic logic [DW-1:0] word(input int a);
        logic signed [31:0] v;
        v = a - 3000;
        return v[DW-1:0];
    endfunction

    // BRAM models with two-cycle read latency.
    always @(posedge clk) begin
        bram_d1   <= word(int'(rd_addr));
        rd_data   <= bram_d1;
        bram_d1_s <= word(int'(rd_addr_s));
        rd_data_s <= bram_d1_s;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream scoreboard and credit invariant, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            check("credit_bound", 32'((outstanding + int'(rd_en)) <= 4), 32'd1);
            check("no_push_full", 32'(dut.fifo_push && (int'(dut.fifo_cnt) == 4)), 32'd0);
            if (m_valid && m_ready) begin
                check("beat_data", 32'(m_data), 32'(word(exp_idx)));
                check("beat_last", 32'(m_last), 32'(exp_idx == N - 1));
                exp_idx++;
            end
            outstanding = outstanding + int'(rd_en) - int'(m_valid && m_ready);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int target, input bit rand_rdy, input string tag);
        int n = 0;
        while (exp_idx < target && n < 20000) begin
            cyc();
            if (rand_rdy) m_ready = ($urandom_range(0, 1) == 1);
            n++;
        end
        if (exp_idx < target) check(tag, 32'(exp_idx), 32'(target));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!drain_done && n < 100) begin
            cyc();
            n++;
        end
        check(tag, 32'(drain_done), 32'd1);
    endtask

    task automatic rearm();
        conv_done = 1'b0;
        cyc();
        cyc();
        exp_idx   = 0;
        conv_done = 1'b1;
    endtask

    int n_rd;

    initial begin
        reset_n = 1'b0; conv_done = 1'b0; m_ready = 1'b0;
        conv_done_s = 1'b0; m_ready_s = 1'b1;
        repeat (3) cyc();
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(drain_done), 32'd0);
        reset_n = 1'b1;
        cyc();

        // Full drain, no backpressure, with first-beat latency.
        m_ready = 1'b1; exp_idx = 0; conv_done = 1'b1;
        cyc();
        check("e0_busy", 32'(busy), 32'd1);
        check("e0_rd_en", 32'(rd_en), 32'd1);
        check("e0_rd_addr", 32'(rd_addr), 32'd0);
        check("e0_m_valid", 32'(m_valid), 32'd0);
        cyc();
        check("e1_rd_addr", 32'(rd_addr), 32'd1);
        check("e1_m_valid", 32'(m_valid), 32'd0);
        cyc();
        check("e2_m_valid", 32'(m_valid), 32'd0);
        cyc();
        check("e3_m_valid", 32'(m_valid), 32'd1);
        check("e3_m_data", 32'(m_data), 32'(word(0)));
        wait_beats(N, 1'b0, "full_timeout");
        check("flush_m_valid", 32'(m_valid), 32'd0);
        check("flush_done", 32'(drain_done), 32'd0);
        check("flush_busy", 32'(busy), 32'd1);
        cyc();
        check("done_high", 32'(drain_done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);

        // conv_done held high through DONE never retriggers.
        repeat (20) cyc();
        check("hold_done", 32'(drain_done), 32'd1);
        check("hold_rd_en", 32'(rd_en), 32'd0);
        check("hold_beats", 32'(exp_idx), 32'(N));
        conv_done = 1'b0;
        cyc();
        check("idle_done", 32'(drain_done), 32'd0);

        // Second drain under random backpressure.
        rearm();
        wait_beats(N, 1'b1, "rand_timeout");
        m_ready = 1'b1;
        wait_done("rand_done");
        repeat (5) cyc();
        check("rand_beats", 32'(exp_idx), 32'(N));

        // Stall: only FIFO_DEPTH reads go out, head held stable.
        conv_done = 1'b0;
        cyc();
        cyc();
        m_ready = 1'b0; exp_idx = 0; conv_done = 1'b1;
        n_rd = 0;
        repeat (12) begin
            cyc();
            if (rd_en) begin
                check("stall_addr", 32'(rd_addr), 32'(n_rd));
                n_rd++;
            end
        end
        check("stall_reads", 32'(n_rd), 32'd4);
        check("stall_rd_en", 32'(rd_en), 32'd0);
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(word(0)));
        repeat (5) cyc();
        check("stall_data_hold", 32'(m_data), 32'(word(0)));
        check("stall_addr_hold", 32'(rd_addr), 32'd3);
        m_ready = 1'b1;
        wait_beats(N, 1'b0, "stall_timeout");
        wait_done("stall_done");

        // Reset mid-drain, no restart while conv_done stays high.
        m_ready = 1'b1;
        rearm();
        wait_beats(100, 1'b0, "mid_timeout");
        reset_n = 1'b0;
        #1;
        check("mid_rd_en", 32'(rd_en), 32'd0);
        check("mid_rd_addr", 32'(rd_addr), 32'd0);
        check("mid_m_valid", 32'(m_valid), 32'd0);
        check("mid_m_data", 32'(m_data), 32'd0);
        check("mid_m_last", 32'(m_last), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_done", 32'(drain_done), 32'd0);
        outstanding = 0;
        cyc();
        reset_n = 1'b1;
        repeat (10) cyc();
        check("norestart_busy", 32'(busy), 32'd0);
        check("norestart_rd_en", 32'(rd_en), 32'd0);
        rearm();
        cyc();
        check("fresh_rd_en", 32'(rd_en), 32'd1);
        check("fresh_rd_addr", 32'(rd_addr), 32'd0);
        wait_beats(N, 1'b0, "fresh_timeout");
        wait_done("fresh_done");

        // NUM_RESULTS=1 instance: one beat with m_last, then DONE.
        conv_done_s = 1'b1;
        cyc();
        check("one_rd_en", 32'(rd_en_s), 32'd1);
        check("one_rd_addr", 32'(rd_addr_s), 32'd0);
        cyc();
        check("one_rd_en_off", 32'(rd_en_s), 32'd0);
        check("one_busy", 32'(busy_s), 32'd1);
        cyc();
        check("one_e2_valid", 32'(m_valid_s), 32'd0);
        cyc();
        check("one_valid", 32'(m_valid_s), 32'd1);
        check("one_last", 32'(m_last_s), 32'd1);
        check("one_data", 32'(m_data_s), 32'(word(0)));
        cyc();
        check("one_empty", 32'(m_valid_s), 32'd0);
        check("one_not_done", 32'(drain_done_s), 32'd0);
        cyc();
        check("one_done", 32'(drain_done_s), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
